// File: rtl/nios_simple_pixel_to_fifo_packer.sv
// Pixel-to-FIFO packer for the Nios video transmit path.
// Accepts an 8-bit-per-symbol Avalon-ST pixel stream with packet framing and
// packs four symbols per 32-bit word (first symbol in [31:24]). Each word
// carries startofpacket, endofpacket and empty. Packed words sit in a 4-entry
// first-word-fall-through FIFO that feeds the 32-bit DMA side.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge exactly when valid and ready are
//   both high. The sink's in_ready is a function of reset_n and the registered
//   FIFO fill only, so it never depends on in_valid. The source's out_valid
//   depends only on the registered fill, so it never depends on out_ready.
//   Once raised, out_valid and the head word stay stable until popped.
module nios_simple_pixel_to_fifo_packer #(
  parameter int SYMBOL_W  = 8,
  parameter int SYMBOLS   = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  // Pixel sink
  output logic                         in_ready,
  input  logic                         in_valid,
  input  logic [SYMBOL_W-1:0]          in_data,
  input  logic                         in_startofpacket,
  input  logic                         in_endofpacket,
  // Packed word source
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [SYMBOL_W*SYMBOLS-1:0]  out_data,
  output logic                         out_startofpacket,
  output logic                         out_endofpacket,
  output logic [1:0]                   out_empty,
  // Status
  output logic [2:0]                   fill_level,
  output logic                         protocol_err,
  // Packing FSM state, for debug and checker binding
  output logic                         dbg_state
);

  localparam int WORD_W = SYMBOL_W * SYMBOLS;

  // Packing FSM states
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  localparam logic [2:0] DEPTH_L = 3'(OUT_DEPTH);

  // Packing state
  logic [0:0]        r_state;
  logic [1:0]        r_lane;
  logic              r_sop_pending;
  logic [WORD_W-1:0] r_asm;
  logic              r_protocol_err;

  // Output FIFO storage and bookkeeping
  logic [WORD_W-1:0] r_mem_data  [0:3];
  logic              r_mem_sop   [0:3];
  logic              r_mem_eop   [0:3];
  logic [1:0]        r_mem_empty [0:3];
  logic [1:0]        r_wr_ptr;
  logic [1:0]        r_rd_ptr;
  logic [2:0]        r_fill;

  // Combinational helpers
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_pop;
  logic              w_write;
  logic              w_err;
  logic [1:0]        w_wr_lane;
  logic              w_wr_sop;
  logic [WORD_W-1:0] w_base;
  logic [WORD_W-1:0] w_word;
  logic              w_complete;
  logic [1:0]        w_push_empty;

  // Ready comes from the registered fill: a pop while full frees space only
  // from the next cycle on.
  assign w_in_ready  = reset_n & (r_fill < DEPTH_L);
  assign w_out_valid = (r_fill != 3'd0);
  assign w_accept    = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  // Decide what an accepted beat does: drop it, start a packet, restart a
  // packet after a misplaced SOP, or extend the current word.
  always_comb begin
    w_write   = 1'b0;
    w_err     = 1'b0;
    w_wr_lane = r_lane;
    w_wr_sop  = r_sop_pending;
    w_base    = r_asm;
    if (w_accept) begin
      if (r_state == ST_IDLE) begin
        if (in_startofpacket) begin
          w_write   = 1'b1;
          w_wr_lane = 2'd0;
          w_wr_sop  = 1'b1;
          w_base    = '0;
        end else begin
          // Pixel outside a packet: dropped.
          w_err = 1'b1;
        end
      end else begin
        if (in_startofpacket) begin
          // New packet before EOP: abandon the partial word and restart.
          w_err     = 1'b1;
          w_write   = 1'b1;
          w_wr_lane = 2'd0;
          w_wr_sop  = 1'b1;
          w_base    = '0;
        end else begin
          w_write = 1'b1;
        end
      end
    end
  end

  // Merge the incoming symbol into its byte lane, first symbol most significant.
  always_comb begin
    w_word = w_base;
    case (w_wr_lane)
      2'd0:    w_word[31:24] = in_data;
      2'd1:    w_word[23:16] = in_data;
      2'd2:    w_word[15:8]  = in_data;
      default: w_word[7:0]   = in_data;
    endcase
  end

  assign w_complete   = w_write & ((w_wr_lane == 2'd3) | in_endofpacket);
  assign w_push_empty = in_endofpacket ? (2'd3 - w_wr_lane) : 2'd0;

  // Packing FSM, lane counter, assembly register and error pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_lane         <= 2'd0;
      r_sop_pending  <= 1'b0;
      r_asm          <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_protocol_err <= w_err;
      if (w_write) begin
        if (w_complete) begin
          r_asm         <= '0;
          r_lane        <= 2'd0;
          r_sop_pending <= 1'b0;
          r_state       <= in_endofpacket ? ST_IDLE : ST_IN_PKT;
        end else begin
          r_asm         <= w_word;
          r_lane        <= w_wr_lane + 2'd1;
          r_sop_pending <= w_wr_sop;
          r_state       <= ST_IN_PKT;
        end
      end
    end
  end

  // FIFO storage write. A push only happens on an accepted beat, which
  // already implies reset is released and the FIFO has room.
  always_ff @(posedge clk) begin
    if (w_complete) begin
      r_mem_data[r_wr_ptr]  <= w_word;
      r_mem_sop[r_wr_ptr]   <= w_wr_sop;
      r_mem_eop[r_wr_ptr]   <= in_endofpacket;
      r_mem_empty[r_wr_ptr] <= w_push_empty;
    end
  end

  // FIFO pointers and occupancy; 2-bit pointers wrap naturally 3 -> 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_fill   <= 3'd0;
    end else begin
      if (w_complete) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_complete, w_pop})
        2'b10:   r_fill <= r_fill + 3'd1;
        2'b01:   r_fill <= r_fill - 3'd1;
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Head word presented straight from storage; forced to zero when empty so
  // stale or uninitialised entries never show on the bus.
  always_comb begin
    if (w_out_valid) begin
      out_data          = r_mem_data[r_rd_ptr];
      out_startofpacket = r_mem_sop[r_rd_ptr];
      out_endofpacket   = r_mem_eop[r_rd_ptr];
      out_empty         = r_mem_empty[r_rd_ptr];
    end else begin
      out_data          = '0;
      out_startofpacket = 1'b0;
      out_endofpacket   = 1'b0;
      out_empty         = 2'd0;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign fill_level   = r_fill;
  assign protocol_err = r_protocol_err;
  assign dbg_state    = r_state;

endmodule

// File: doc/nios_simple_pixel_to_fifo_packer.md
Name: nios_simple_pixel_to_fifo_packer

Overview:
- Transmit-side counterpart of the FIFO-to-pixel path. It accepts an 8-bit-per-symbol Avalon-ST pixel stream with packet framing and packs 4 symbols into 32-bit words with startofpacket, endofpacket and empty.
- Packed words are buffered in a 4-entry output FIFO with backpressure. The FIFO feeds the 32-bit DMA/FIFO side of the Nios video pipeline.

Parameters:
- SYMBOL_W, 8, bits per input pixel symbol. Fixed at 8.
- SYMBOLS, 4, symbols per output word. Fixed at 4, so empty is 2 bits.
- OUT_DEPTH, 4, output FIFO entries.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active-low.
- in_ready  out  1  sink ready.
- in_valid  in  1  pixel valid.
- in_data  in  8  pixel symbol.
- in_startofpacket  in  1  first pixel of packet.
- in_endofpacket  in  1  last pixel of packet.
- out_ready  in  1  downstream ready.
- out_valid  out  1  word valid.
- out_data  out  32  packed word. The first symbol is in [31:24].
- out_startofpacket  out  1  word holds the first pixel.
- out_endofpacket  out  1  word holds the last pixel.
- out_empty  out  2  unused symbols in an EOP word (low-order bytes).
- fill_level  out  3  output FIFO occupancy, 0..4.
- protocol_err  out  1  one-cycle pulse on a framing violation.

Behaviour:
- Interface decision: one clock, clk. Reset is reset_n, synchronous and active-low; it is sampled only on rising clk.
- Reset values:
  - in_ready=0 while reset_n=0.
  - out_valid=0, fill_level=0, protocol_err=0.
  - Lane counter=0, sop_pending=0, state=IDLE.
  - out_data, out_startofpacket, out_endofpacket and out_empty are 0 while the FIFO is empty.
- Handshakes:
  - Beat accepted = in_valid & in_ready. in_ready = reset_n & (fill_level < OUT_DEPTH), computed from the registered fill.
  - When full, a same-cycle pop does not raise in_ready. in_ready rises the cycle after the pop.
  - Word popped = out_valid & out_ready. out_valid = (fill_level != 0). Head word is presented from registers (first-word fall-through).
- State machine:
  - IDLE: an accepted beat with SOP=1 loads symbol lane 0 into [31:24], sets sop_pending, sets lane=1, and moves to IN_PKT. An accepted beat with SOP=0 is dropped and pulses protocol_err.
  - IN_PKT: each accepted beat writes byte lane[lane], i.e. bits [31-8*lane -: 8], and increments lane.
- Word completion happens when lane==3 or EOP=1 on the accepted beat. The assembled word is pushed with:
  - sop = sop_pending
  - eop = EOP
  - empty = EOP ? 3-lane : 0
- After a push:
  - Clear sop_pending and the assembly register, and set lane=0.
  - If EOP=1, go to IDLE; otherwise stay in IN_PKT.
- SOP+EOP on the same beat in IDLE pushes a single word with sop=1, eop=1, empty=3.
- SOP received while in IN_PKT:
  - Discard the partial word and pulse protocol_err.
  - Restart assembly with this beat as lane 0 and set sop_pending.
  - No word is pushed for the aborted packet.
- Latency: a completing beat accepted at edge N gives out_valid=1 with that word at edge N+1 if the FIFO was empty.
- Simultaneous push and pop: fill is unchanged and ordering is preserved. Write and read pointers are 2 bits and wrap 3→0.
- Non-completing beats still require in_ready=1. There is no special acceptance when full.
- Reset mid-packet: all state, FIFO contents and partial words are discarded. Nothing is output after release until a new SOP.

Test Plan:
1. Packet of 8 pixels 0x01..0x08, SOP on the first beat, EOP on the last, out_ready=1 → words 0x01020304 (sop=1, eop=0, empty=0) and 0x05060708 (sop=0, eop=1, empty=0), each one cycle after its 4th beat.
2. Packet of 6 pixels 0xA0..0xA5 → 0xA0A1A2A3 (sop=1), then 0xA4A50000 (eop=1, empty=2). A one-pixel packet 0x7F → 0x7F000000 (sop=1, eop=1, empty=3).
3. out_ready=0 while streaming 16+ pixels → fill_level reaches 4 and in_ready drops to 0. Raise out_ready → in_ready returns the cycle after the first pop, with no loss or reordering.
4. Pixel with SOP=0 in IDLE → dropped, 1-cycle protocol_err. SOP on the 3rd beat of a packet → protocol_err, partial word discarded, next output word begins with that beat's pixel and has sop=1.
5. Assert reset_n=0 for 1 cycle after 2 pixels of a packet → out_valid=0, fill_level=0, in_ready=0 during reset. After release, a fresh packet packs from lane 0.
6. Random valid/ready throttling with 1000 random-length packets → scoreboard matches byte order, sop/eop/empty, and fill_level never exceeds 4.
